// File: rtl/ct_mat_exu_alu_row_seq.sv
// Row sequencer behind the matrix ALU EX1 stage: it strobes one row per
// datapath-ready cycle, waits out the drain latency, then retires the iid on pipe8.
module ct_mat_exu_alu_row_seq #(
  parameter int IID_WIDTH = 7,
  parameter int OP_WIDTH  = 11,
  parameter int ROW_WIDTH = 8,
  parameter int DRAIN_LAT = 2
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  input  logic                 rtu_yy_xx_flush,
  input  logic                 ex1_inst_vld,
  input  logic [IID_WIDTH-1:0] ex1_iid,
  input  logic [OP_WIDTH-1:0]  ex1_op,
  input  logic [2:0]           ex1_dstm_idx,
  input  logic [ROW_WIDTH-1:0] x_sizeM,
  input  logic                 dp_row_ready,
  output logic                 seq_ex1_ready,
  output logic                 seq_dp_row_vld,
  output logic [ROW_WIDTH-1:0] seq_dp_row_idx,
  output logic [OP_WIDTH-1:0]  seq_dp_op,
  output logic [2:0]           seq_dp_dstm_idx,
  output logic                 seq_dp_last_row,
  output logic                 mat_alu_cbus_ex2_pipe8_sel,
  output logic [IID_WIDTH-1:0] mat_alu_cbus_ex2_pipe8_iid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROW   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] CMPLT = 2'd3;

  localparam logic [3:0]           DRAIN_INIT = 4'(DRAIN_LAT);
  localparam logic [ROW_WIDTH-1:0] ROW_ONE    = ROW_WIDTH'(1);

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [ROW_WIDTH-1:0] row_cnt;
  logic [ROW_WIDTH-1:0] row_cnt_nxt;
  logic [3:0]           drain_cnt;
  logic [3:0]           drain_cnt_nxt;
  logic [IID_WIDTH-1:0] iid_q;
  logic [OP_WIDTH-1:0]  op_q;
  logic [2:0]           dstm_q;
  logic [ROW_WIDTH-1:0] sizem_q;

  logic accept;
  logic row_last;

  // Ready is a pure state decode; flush only blocks the accept itself.
  assign seq_ex1_ready = (state == IDLE) || (state == CMPLT);
  assign accept        = ex1_inst_vld && seq_ex1_ready && !rtu_yy_xx_flush;

  // Only evaluated in ROW, where sizem_q is known to be non-zero.
  assign row_last = (row_cnt == (sizem_q - ROW_ONE));

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_nxt     = state;
    row_cnt_nxt   = row_cnt;
    drain_cnt_nxt = drain_cnt;
    if (rtu_yy_xx_flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, CMPLT: begin
          state_nxt = IDLE;
          if (accept) begin
            row_cnt_nxt = '0;
            if (x_sizeM != '0) begin
              state_nxt = ROW;
            end else begin
              state_nxt     = DRAIN;
              drain_cnt_nxt = DRAIN_INIT;
            end
          end
        end
        ROW: begin
          if (dp_row_ready) begin
            if (row_last) begin
              state_nxt     = DRAIN;
              drain_cnt_nxt = DRAIN_INIT;
            end else begin
              row_cnt_nxt = row_cnt + ROW_ONE;
            end
          end
        end
        DRAIN: begin
          drain_cnt_nxt = drain_cnt - 4'd1;
          if (drain_cnt == 4'd1) begin
            state_nxt = CMPLT;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state     <= IDLE;
      row_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      row_cnt   <= row_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Instruction fields are captured only on accept; flush leaves them untouched.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      iid_q   <= '0;
      op_q    <= '0;
      dstm_q  <= '0;
      sizem_q <= '0;
    end else if (accept) begin
      iid_q   <= ex1_iid;
      op_q    <= ex1_op;
      dstm_q  <= ex1_dstm_idx;
      sizem_q <= x_sizeM;
    end
  end

  assign seq_dp_row_vld             = (state == ROW) && !rtu_yy_xx_flush;
  assign seq_dp_row_idx             = row_cnt;
  assign seq_dp_op                  = op_q;
  assign seq_dp_dstm_idx            = dstm_q;
  assign seq_dp_last_row            = (state == ROW) && row_last;
  assign mat_alu_cbus_ex2_pipe8_sel = (state == CMPLT) && !rtu_yy_xx_flush;
  assign mat_alu_cbus_ex2_pipe8_iid = iid_q;

endmodule

// File: tb/tb_ct_mat_exu_alu_row_seq.sv
// Bench for the ALU row sequencer: directed latency/flush scenarios plus random
// traffic, all checked each cycle against a per-instruction progress model.
module tb_ct_mat_exu_alu_row_seq;

  localparam int IW = 7;
  localparam int OW = 11;
  localparam int RW = 8;
  localparam int DL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          vld = 1'b0;
  logic [IW-1:0] iid = '0;
  logic [OW-1:0] op = '0;
  logic [2:0]    dstm = '0;
  logic [RW-1:0] sizem = '0;
  logic          dp_ready = 1'b0;

  logic          ready;
  logic          row_vld;
  logic [RW-1:0] row_idx;
  logic [OW-1:0] dp_op;
  logic [2:0]    dp_dstm;
  logic          last_row;
  logic          sel;
  logic [IW-1:0] cb_iid;

  ct_mat_exu_alu_row_seq #(
    .IID_WIDTH(IW), .OP_WIDTH(OW), .ROW_WIDTH(RW), .DRAIN_LAT(DL)
  ) dut (
    .forever_cpuclk             (clk),
    .cpurst_b                   (rst_n),
    .rtu_yy_xx_flush            (flush),
    .ex1_inst_vld               (vld),
    .ex1_iid                    (iid),
    .ex1_op                     (op),
    .ex1_dstm_idx               (dstm),
    .x_sizeM                    (sizem),
    .dp_row_ready               (dp_ready),
    .seq_ex1_ready              (ready),
    .seq_dp_row_vld             (row_vld),
    .seq_dp_row_idx             (row_idx),
    .seq_dp_op                  (dp_op),
    .seq_dp_dstm_idx            (dp_dstm),
    .seq_dp_last_row            (last_row),
    .mat_alu_cbus_ex2_pipe8_sel (sel),
    .mat_alu_cbus_ex2_pipe8_iid (cb_iid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Event logs used by the directed scenarios
  typedef struct { int c; logic [RW-1:0] idx; logic last; } row_ev_t;
  typedef struct { int c; logic [IW-1:0] id; } sel_ev_t;
  row_ev_t row_q[$];
  sel_ev_t sel_q[$];

  always @(negedge clk) begin
    if (rst_n && row_vld === 1'b1) row_q.push_back('{c: cyc, idx: row_idx, last: last_row});
    if (rst_n && sel === 1'b1)     sel_q.push_back('{c: cyc, id: cb_iid});
  end

  // Model: one in-flight instruction, tracked by rows strobed and drain cycles left.
  bit            m_act = 1'b0;
  logic [IW-1:0] m_iid;
  logic [OW-1:0] m_op;
  logic [2:0]    m_dstm;
  int            m_size, m_rows, m_drain;
  bit            e_ret, e_ready, e_row;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0;
      check("rst_ready", ready, 1);
      check("rst_row_vld", row_vld, 0);
      check("rst_sel", sel, 0);
    end else begin
      e_ret   = m_act && (m_rows >= m_size) && (m_drain == 0);
      e_ready = !m_act || e_ret;
      e_row   = m_act && (m_rows < m_size) && !flush;
      check("ready", ready, e_ready);
      check("row_vld", row_vld, e_row);
      check("sel", sel, e_ret && !flush);
      if (e_row) begin
        check("row_idx", row_idx, m_rows);
        check("last_row", last_row, m_rows == m_size - 1);
        check("dp_op", dp_op, m_op);
        check("dp_dstm", dp_dstm, m_dstm);
      end
      if (e_ret && !flush) check("cbus_iid", cb_iid, m_iid);
      if (flush) begin
        m_act = 1'b0;
      end else begin
        if (m_act) begin
          if (m_rows < m_size) begin
            if (dp_ready) m_rows++;
          end else if (m_drain > 0) begin
            m_drain--;
          end else begin
            m_act = 1'b0;
          end
        end
        if (e_ready && vld) begin
          m_act   = 1'b1;
          m_iid   = iid;
          m_op    = op;
          m_dstm  = dstm;
          m_size  = int'(sizem);
          m_rows  = 0;
          m_drain = DL;
        end
      end
    end
  end

  task automatic wait_sel(output int c);
    c = -1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (sel === 1'b1) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check("sel_timeout", 0, 1);
  endtask

  task automatic issue(input logic [IW-1:0] id, input logic [RW-1:0] sz, output int a);
    @(posedge clk); #1;
    vld = 1'b1; iid = id; sizem = sz; op = 11'h004; dstm = 3'd5; dp_ready = 1'b1;
    a = cyc;
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic goto_cycle(input int target);
    for (int k = 0; k < 100 && cyc < target; k++) begin
      @(posedge clk); #1;
    end
  endtask

  int a, c, r;
  int exp_idx[5] = '{0, 1, 1, 1, 2};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_row_vld", row_vld, 0);
    check("reset_row_idx", row_idx, 0);
    check("reset_last_row", last_row, 0);
    check("reset_op", dp_op, 0);
    check("reset_dstm", dp_dstm, 0);
    check("reset_sel", sel, 0);
    check("reset_iid", cb_iid, 0);

    // sizeM=4: rows in cycles 1..4, retire in cycle 7
    row_q.delete(); sel_q.delete();
    issue(7'h15, 8'd4, a);
    wait_sel(c);
    check("t1_sel_cycle", c - a, 7);
    check("t1_sel_iid", cb_iid, 7'h15);
    repeat (4) @(negedge clk);
    check("t1_row_count", row_q.size(), 4);
    for (int i = 0; i < row_q.size() && i < 4; i++) begin
      check("t1_row_cycle", row_q[i].c - a, i + 1);
      check("t1_row_idx", row_q[i].idx, i);
      check("t1_row_last", row_q[i].last, i == 3);
    end
    check("t1_sel_count", sel_q.size(), 1);

    // sizeM=0: ready low in cycles 1-2, retire in cycle 3
    row_q.delete(); sel_q.delete();
    issue(7'h03, 8'd0, a);
    @(negedge clk); check("t2_ready_c1", ready, 0);
    @(negedge clk); check("t2_ready_c2", ready, 0);
    @(negedge clk);
    check("t2_sel", sel, 1);
    check("t2_sel_cycle", cyc - a, 3);
    check("t2_iid", cb_iid, 7'h03);
    @(negedge clk); check("t2_ready_after", ready, 1);
    check("t2_no_rows", row_q.size(), 0);

    // sizeM=3 with ready low in cycles 2-3 and x_sizeM moved after accept
    row_q.delete(); sel_q.delete();
    @(posedge clk); #1;
    vld = 1'b1; iid = 7'h0A; sizem = 8'd3; dp_ready = 1'b1; a = cyc;
    @(posedge clk); #1; vld = 1'b0; sizem = 8'd9;
    @(posedge clk); #1; dp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; dp_ready = 1'b1;
    wait_sel(c);
    check("t3_sel_cycle", c - a, 8);
    repeat (2) @(negedge clk);
    check("t3_row_count", row_q.size(), 5);
    for (int i = 0; i < row_q.size() && i < 5; i++) begin
      check("t3_row_cycle", row_q[i].c - a, i + 1);
      check("t3_row_idx", row_q[i].idx, exp_idx[i]);
      check("t3_row_last", row_q[i].last, i == 4);
    end

    // Back-to-back: second instruction presented during the first's retire cycle
    row_q.delete(); sel_q.delete();
    issue(7'h11, 8'd2, a);
    goto_cycle(a + 5);
    vld = 1'b1; iid = 7'h20; sizem = 8'd1;
    @(negedge clk);
    check("t4_sel1", sel, 1);
    check("t4_sel1_cycle", cyc - a, 5);
    check("t4_iid1", cb_iid, 7'h11);
    check("t4_ready_cmplt", ready, 1);
    @(posedge clk); #1; vld = 1'b0;
    wait_sel(c);
    check("t4_sel2_cycle", c - a, 9);
    check("t4_iid2", cb_iid, 7'h20);
    @(negedge clk);
    check("t4_row_count", row_q.size(), 3);
    if (row_q.size() == 3) begin
      check("t4_row2_cycle", row_q[2].c - a, 6);
      check("t4_row2_idx", row_q[2].idx, 0);
      check("t4_row2_last", row_q[2].last, 1);
    end

    // Flush at row 2 of sizeM=8
    row_q.delete(); sel_q.delete();
    issue(7'h2C, 8'd8, a);
    goto_cycle(a + 3);
    flush = 1'b1;
    @(negedge clk);
    check("t5_flush_row_vld", row_vld, 0);
    check("t5_flush_idx", row_idx, 2);
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("t5_ready_after", ready, 1);
    repeat (20) @(negedge clk);
    check("t5_no_sel", sel_q.size(), 0);
    check("t5_rows", row_q.size(), 2);

    // Flush in the retire cycle with a coincident accept
    row_q.delete(); sel_q.delete();
    issue(7'h2A, 8'd1, a);
    goto_cycle(a + 4);
    flush = 1'b1; vld = 1'b1; iid = 7'h33; sizem = 8'd2;
    @(negedge clk);
    check("t6_sel_suppressed", sel, 0);
    check("t6_ready", ready, 1);
    @(posedge clk); #1; flush = 1'b0; vld = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_no_sel", sel_q.size(), 0);
    check("t6_rows", row_q.size(), 1);
    check("t6_idle_ready", ready, 1);

    // Random traffic, one asynchronous reset in the middle
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      rst_n    = (k == 1500) ? 1'b0 : 1'b1;
      vld      = 1'($urandom_range(0, 1));
      iid      = IW'($urandom);
      op       = 11'(1) << $urandom_range(0, 10);
      dstm     = 3'($urandom);
      r        = int'($urandom_range(0, 99));
      sizem    = (r < 2) ? 8'd255 : (r < 12) ? 8'd0 : 8'($urandom_range(1, 6));
      dp_ready = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 99) < 2);
    end
    @(posedge clk); #1;
    vld = 1'b0; flush = 1'b0; dp_ready = 1'b1;
    repeat (300) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
